grf_dump_reader: RTL and testbench

- Debug/trace reader for the 32x32 general register file.
- On a start pulse it walks GRF read addresses 0..NREG-1 through one read port. It sends each {address, data} pair out over a valid/ready stream.
- Sits beside the datapath and borrows one GRF read port (A-port mux owned by the top level) while busy.
- Used by the bench and the debug UART to snapshot architectural state after a program halts.

---
 rtl/grf_dump_reader.sv | 86 ++++++++
 tb/tb_grf_dump_reader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/grf_dump_reader.sv
// Debug/trace reader: walks GRF addresses 0..NREG-1 through one borrowed read port
// and streams each {address, data} pair over a valid/ready interface.
module grf_dump_reader #(
  parameter int NREG      = 32,
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  logic [1:0]    state;
  logic [AW-1:0] idx;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_data;

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; the captured entry is reset too because it drives ports directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      cap_addr <= '0;
      cap_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx   <= '0;
            state <= S_READ;
          end
        end
        S_READ: begin
          cap_data <= rd_data;
          cap_addr <= idx;
          if (SKIP_ZERO && (rd_data == '0)) begin
            if (idx == LAST_IDX) state <= S_FIN;
            else                 idx   <= idx + 1'b1;
          end else begin
            state <= S_SEND;
          end
        end
        S_SEND: begin
          // idx and the captured entry stay frozen until the consumer accepts
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              state <= S_FIN;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_READ;
            end
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rd_addr   = idx;
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_SEND);
  assign done      = (state == S_FIN);
  assign out_addr  = cap_addr;
  assign out_data  = cap_data;
  assign out_last  = out_valid & (cap_addr == LAST_IDX);

endmodule

// File: tb/tb_grf_dump_reader.sv
// Self-checking bench for grf_dump_reader: a reference walk of the GRF model fills
// a scoreboard at start; the stream monitor pops and compares entries, timing and done.
module tb_grf_dump_reader;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
    int            hs_cyc;
  } entry_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start;
  logic          out_ready;
  logic          use_skip;
  logic [DW-1:0] grf [NREG];

  logic          busy0, busy1, out_valid0, out_valid1, out_last0, out_last1, done0, done1;
  logic [AW-1:0] rd_addr0, rd_addr1, out_addr0, out_addr1;
  logic [DW-1:0] rd_data0, rd_data1, out_data0, out_data1;
  logic          start0, start1;

  assign start0   = start & ~use_skip;
  assign start1   = start & use_skip;
  assign rd_data0 = grf[rd_addr0];
  assign rd_data1 = grf[rd_addr1];

  grf_dump_reader #(.NREG(NREG), .AW(AW), .DW(DW), .SKIP_ZERO(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .rd_addr(rd_addr0),
    .rd_data(rd_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_addr(out_addr0), .out_data(out_data0), .out_last(out_last0), .done(done0)
  );

  grf_dump_reader #(.NREG(NREG), .AW(AW), .DW(DW), .SKIP_ZERO(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .rd_addr(rd_addr1),
    .rd_data(rd_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_addr(out_addr1), .out_data(out_data1), .out_last(out_last1), .done(done1)
  );

  logic          o_busy, o_valid, o_last, o_done;
  logic [AW-1:0] o_addr, o_rd_addr;
  logic [DW-1:0] o_data;
  assign o_busy    = use_skip ? busy1      : busy0;
  assign o_valid   = use_skip ? out_valid1 : out_valid0;
  assign o_last    = use_skip ? out_last1  : out_last0;
  assign o_done    = use_skip ? done1      : done0;
  assign o_addr    = use_skip ? out_addr1  : out_addr0;
  assign o_data    = use_skip ? out_data1  : out_data0;
  assign o_rd_addr = use_skip ? rd_addr1   : rd_addr0;

  int     checks   = 0;
  int     failures = 0;
  entry_t sb [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference walk: cycle 1 reads idx 0; a skipped read costs one cycle, a sent
  // entry costs READ + SEND plus any stall cycles; done follows the final step.
  task automatic build_expect(input bit skip, input int stall_addr, input int stall_n,
                              output int done_cyc);
    int     t;
    int     hs;
    entry_t e;
    t        = 1;
    done_cyc = 0;
    sb.delete();
    for (int i = 0; i < NREG; i++) begin
      if (skip && grf[i] == '0) begin
        if (i == NREG - 1) done_cyc = t + 1;
        t = t + 1;
      end else begin
        hs       = t + 1 + ((i == stall_addr) ? stall_n : 0);
        e.addr   = AW'(i);
        e.data   = grf[i];
        e.last   = (i == NREG - 1);
        e.hs_cyc = hs;
        sb.push_back(e);
        if (i == NREG - 1) done_cyc = hs + 1;
        t = hs + 1;
      end
    end
  endtask

  task automatic run_dump(input bit skip, input int stall_addr, input int stall_n,
                          input int r1, input int r2, input int abort_cyc, input string name);
    int     done_exp;
    int     ndone;
    int     stalled;
    int     hold;
    entry_t e;
    ndone    = 0;
    stalled  = 0;
    hold     = 0;
    use_skip = skip;
    build_expect(skip, stall_addr, stall_n, done_exp);
    @(negedge clk);
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= done_exp + 3; cyc++) begin
      @(negedge clk);
      if (cyc == abort_cyc) begin
        check({name, ":pre_valid"}, o_valid, 1'b1);
        check({name, ":pre_addr"}, o_addr, 12);
        #1 reset = 1'b0;
        #1;
        check({name, ":rst_valid"}, o_valid, 1'b0);
        check({name, ":rst_busy"}, o_busy, 1'b0);
        check({name, ":rst_rd_addr"}, o_rd_addr, 0);
        check({name, ":rst_done"}, o_done, 1'b0);
        check({name, ":rst_out_data"}, o_data, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check({name, ":post_rst_done"}, o_done, 1'b0);
          check({name, ":post_rst_busy"}, o_busy, 1'b0);
        end
        sb.delete();
        return;
      end
      out_ready = 1'b1;
      if (o_valid && o_addr == stall_addr && stalled < stall_n) begin
        out_ready = 1'b0;
        stalled++;
      end
      start = (cyc == r1 || cyc == r2);
      check({name, ":done"}, o_done, cyc == done_exp);
      check({name, ":busy"}, o_busy, cyc <= done_exp);
      if (o_valid) begin
        if (sb.size() == 0) begin
          check({name, ":extra_valid"}, o_valid, 1'b0);
        end else begin
          e = sb[0];
          check({name, ":addr"}, o_addr, e.addr);
          check({name, ":data"}, o_data, e.data);
          check({name, ":last"}, o_last, e.last);
          if (o_addr == stall_addr) hold++;
          if (out_ready) begin
            check({name, ":hs_cycle"}, cyc, e.hs_cyc);
            void'(sb.pop_front());
          end
        end
      end
      if (o_done) ndone++;
    end
    start = 1'b0;
    check({name, ":entries_left"}, sb.size(), 0);
    check({name, ":done_count"}, ndone, 1);
    if (stall_n > 0) check({name, ":hold_cycles"}, hold, stall_n + 1);
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    use_skip  = 1'b0;
    for (int i = 0; i < NREG; i++) grf[i] = '0;
    #12;
    check("reset:busy0", busy0, 1'b0);
    check("reset:valid0", out_valid0, 1'b0);
    check("reset:rd_addr0", rd_addr0, 0);
    check("reset:done0", done0, 1'b0);
    check("reset:out_data0", out_data0, 0);
    check("reset:busy1", busy1, 1'b0);
    check("reset:last1", out_last1, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NREG; i++) grf[i] = i * 32'h0101_0101;
    run_dump(1'b0, -1, 0, -1, -1, -1, "full");
    run_dump(1'b0, 5, 3, -1, -1, -1, "backpressure");
    run_dump(1'b0, -1, 0, 10, 65, -1, "restart_busy");
    run_dump(1'b0, -1, 0, -1, -1, 26, "abort");
    run_dump(1'b0, -1, 0, -1, -1, -1, "after_reset");

    for (int i = 0; i < NREG; i++) grf[i] = '0;
    grf[3]  = 32'hDEAD_BEEF;
    grf[31] = 32'h0000_0001;
    run_dump(1'b1, -1, 0, -1, -1, -1, "skip_two");

    for (int i = 0; i < NREG; i++) grf[i] = '0;
    grf[7] = 32'h0000_0042;
    run_dump(1'b1, -1, 0, -1, -1, -1, "skip_tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
